fifo_pkt_reader: RTL and testbench
==================================

# fifo_pkt_reader

Read-side controller for the router's input FIFOs. It pops flits from a show-ahead FIFO and parses packet framing from the head flit's length field. Flits go out through a single registered valid/ready stage, tagged with head/tail markers. It sits between an input FIFO and the router's output arbitration/crossbar stage.

## Interface
Parameters:
- `WIDTH`, 16: flit width in bits.
- `SZ_W`, 4: width of the length field, located at `[WIDTH-1 -: SZ_W]` of a head flit. The field holds the number of body flits that follow the head.
- `CNT_W`, 8: width of the completed-packet counter.
- `TIMEOUT`, 16: stall limit in cycles. Used only when `FIFO_RD_TIMEOUT_EN` is defined. Must be ≥ 1.

Ports:
- `clk`, input, 1: clock. All logic is on the rising edge.
- `arst`, input, 1: reset. Synchronous and active-high; sampled only on the `clk` rising edge.
- `fifo_empty_i`, input, 1: FIFO empty flag.
- `fifo_data_i`, input, `WIDTH`: FIFO head flit. It is valid whenever `fifo_empty_i` = 0.
- `fifo_rd_o`, output, 1: pop strobe. Combinational.
- `valid_o`, output, 1: output flit valid. Registered.
- `ready_i`, input, 1: downstream accept.
- `data_o`, output, `WIDTH`: output flit. Registered.
- `head_o`, output, 1: the flit on `data_o` is a head flit.
- `tail_o`, output, 1: the flit on `data_o` is the last flit of its packet. Single-flit packets assert both `head_o` and `tail_o`.
- `busy_o`, output, 1: a packet is in progress (FSM is in BODY).
- `pkt_cnt_o`, output, `CNT_W`: number of tail flits accepted downstream. Wraps modulo 2^`CNT_W`.
- `error_o`, output, 1: one-cycle pulse when a packet is aborted on timeout.

## Operation
- Pop rule: `fifo_rd_o` = `~arst & ~fifo_empty_i & (~valid_o | ready_i)`.
  - A pop loads `fifo_data_i` into the output register, so the register is refilled in the same cycle it is drained. Full throughput is one flit per cycle.
- Output register:
  - On a pop: `valid_o` ← 1, `data_o` ← `fifo_data_i`, and `head_o`/`tail_o` are computed from the FSM state.
  - On `valid_o & ready_i` with no pop: `valid_o` ← 0. `data_o`, `head_o` and `tail_o` hold their values.
  - While `valid_o` = 1 and `ready_i` = 0, all of `data_o`, `head_o` and `tail_o` are stable.
- The FSM is advanced only by pops. It has two states:
  - IDLE (expect head): on a pop, `len` = `fifo_data_i[WIDTH-1 -: SZ_W]`. The flit is marked `head_o` = 1.
    - If `len` = 0: `tail_o` = 1 and the FSM stays in IDLE.
    - Otherwise: `rem` ← `len`, `tail_o` = 0, and the FSM goes to BODY.
  - BODY: on a pop, `head_o` = 0 and `rem` ← `rem` − 1.
    - If `rem` = 1 before the pop: `tail_o` = 1 and the FSM goes to IDLE.
- `rem` is `SZ_W` bits wide and cannot underflow, because BODY always exits when `rem` = 1.
- `pkt_cnt_o` increments by 1 on each cycle with `valid_o & ready_i & tail_o`. It wraps from 2^`CNT_W`−1 to 0.
- `busy_o` = (state == BODY).
- `fifo_data_i` is ignored while `fifo_empty_i` = 1.

## Timing
- Reset values: `valid_o` 0, `data_o` 0, `head_o` 0, `tail_o` 0, `busy_o` 0, `pkt_cnt_o` 0, `error_o` 0. State is IDLE, `rem` is 0, and `fifo_rd_o` is 0 during reset.
- Reset mid-packet discards both the output register contents and the partial packet. The first pop after reset is treated as a head flit.
- Latency: a flit present at the FIFO head in cycle N, with the register free, appears on `data_o` in cycle N+1.
- Backpressure: while `valid_o & ~ready_i`, `fifo_rd_o` = 0 and nothing is popped.
- Simultaneous drain and refill: with `valid_o & ready_i & ~fifo_empty_i`, the old flit is accepted and the new flit is loaded in the same edge, so `valid_o` stays 1.
- FIFO empty while in BODY: the FSM holds state and `rem`. Without the macro it waits indefinitely.

## Configuration
- `FIFO_RD_TIMEOUT_EN` defined:
  - A stall counter of `$clog2(TIMEOUT+1)` bits counts consecutive BODY cycles with `fifo_empty_i` = 1. It clears on any pop and on leaving BODY.
  - When the counter reaches `TIMEOUT`: `error_o` pulses for 1 cycle, the FSM goes to IDLE, `rem` ← 0, and the counter clears.
  - The already-issued flits are not retracted. No tail is emitted for the aborted packet, and `pkt_cnt_o` is unchanged.
  - The next popped flit is parsed as a head.
- Undefined: no stall counter is built, `error_o` is tied to 0, and BODY waits without limit.

## Test plan
- Single-flit packet: push 0x0ABC with `ready_i` = 1. Expect one cycle later `data_o` = 0x0ABC, `head_o` = 1, `tail_o` = 1, then `pkt_cnt_o` = 1 and `busy_o` = 0.
- Back-to-back packets: push 0x2001, 0x0002, 0x0003, then 0x1004, 0x0005, with `ready_i` = 1.
  - Expect `valid_o` high for 5 consecutive cycles.
  - Expect the head/tail pattern H, -, T, H, T.
  - Expect `pkt_cnt_o` = 2 at the end.
- Backpressure: the 3-flit packet above with `ready_i` = 0 for 4 cycles after the first flit is loaded.
  - Expect `data_o` held at 0x2001, `fifo_rd_o` = 0 throughout, and no flits lost or duplicated after release.
- Reset mid-packet: assert `arst` after the head 0x3000 and one body flit.
  - Expect all outputs back at their reset values.
  - Then push 0x0011 and expect `head_o` = 1, `tail_o` = 1.
- Timeout (macro on, `TIMEOUT` = 4): push head 0x2000 and one body flit, then leave the FIFO empty.
  - Expect `error_o` high for exactly one cycle, 4 cycles after the last pop, with `busy_o` → 0 and `pkt_cnt_o` unchanged.
  - The next flit is parsed as a head.
- Counter wrap: with `CNT_W` = 2, send 5 single-flit packets. Expect `pkt_cnt_o` to step 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/fifo_pkt_reader_if.sv
// Handshake bundle between the input FIFO, the packet reader and the
// downstream arbitration stage.
interface fifo_pkt_reader_if #(
  parameter int WIDTH = 16
);
  logic             fifo_empty_i;
  logic [WIDTH-1:0] fifo_data_i;
  logic             fifo_rd_o;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] data_o;
  logic             head_o;
  logic             tail_o;

  modport master (
    input  fifo_empty_i,
    input  fifo_data_i,
    input  ready_i,
    output fifo_rd_o,
    output valid_o,
    output data_o,
    output head_o,
    output tail_o
  );

  modport slave (
    output fifo_empty_i,
    output fifo_data_i,
    output ready_i,
    input  fifo_rd_o,
    input  valid_o,
    input  data_o,
    input  head_o,
    input  tail_o
  );
endinterface

// File: rtl/fifo_pkt_reader.sv
// Input-FIFO read controller: pops flits, tags head/tail from the length field.
// Optional body-stall abort is enabled with FIFO_RD_TIMEOUT_EN.
module fifo_pkt_reader #(
  parameter int WIDTH   = 16,
  parameter int SZ_W    = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             arst,
  fifo_pkt_reader_if.master bus,
  output logic             busy_o,
  output logic [CNT_W-1:0] pkt_cnt_o,
  output logic             error_o
);

  typedef enum logic {
    IDLE,
    BODY
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [SZ_W-1:0]  rem_q;
  logic [SZ_W-1:0]  rem_d;
  logic [SZ_W-1:0]  len;
  logic             pop;
  logic             acc;
  logic             head_d;
  logic             tail_d;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             head_q;
  logic             tail_q;
  logic [CNT_W-1:0] cnt_q;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fifo_pkt_reader: TIMEOUT must be >= 1");
  end

  assign len = bus.fifo_data_i[WIDTH-1 -: SZ_W];
  // refill in the same cycle the register drains
  assign pop = ~arst & ~bus.fifo_empty_i & (~valid_q | bus.ready_i);
  assign acc = valid_q & bus.ready_i;

`ifdef FIFO_RD_TIMEOUT_EN
  localparam int ST_W = $clog2(TIMEOUT + 1);
  localparam logic [ST_W-1:0] ST_LIM = ST_W'(TIMEOUT - 1);

  logic [ST_W-1:0] stall_q;
  logic [ST_W-1:0] stall_d;
  logic            err_q;
  logic            err_d;
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    head_d  = 1'b0;
    tail_d  = 1'b0;
`ifdef FIFO_RD_TIMEOUT_EN
    stall_d = '0;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          head_d = 1'b1;
          if (len == '0) begin
            tail_d = 1'b1;
          end else begin
            rem_d   = len;
            state_d = BODY;
          end
        end
      end
      BODY: begin
        if (pop) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == SZ_W'(1)) begin
            tail_d  = 1'b1;
            state_d = IDLE;
          end
        end
`ifdef FIFO_RD_TIMEOUT_EN
        else if (bus.fifo_empty_i) begin
          // abort: issued flits stay, no tail is fabricated
          if (stall_q == ST_LIM) begin
            err_d   = 1'b1;
            state_d = IDLE;
            rem_d   = '0;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

`ifdef FIFO_RD_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (arst) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign error_o = err_q;
`else
  assign error_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (arst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
    end else if (pop) begin
      valid_q <= 1'b1;
      data_q  <= bus.fifo_data_i;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end else if (acc) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      cnt_q <= '0;
    end else if (acc & tail_q) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.fifo_rd_o = pop;
  assign bus.valid_o   = valid_q;
  assign bus.data_o    = data_q;
  assign bus.head_o    = head_q;
  assign bus.tail_o    = tail_q;
  assign busy_o        = (state_q == BODY);
  assign pkt_cnt_o     = cnt_q;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Bench for fifo_pkt_reader: directed vector table, stall/abort sequence,
// and randomized packet traffic against a packet-level reference model.
module tb_fifo_pkt_reader;
  localparam int W  = 16;
  localparam int CW = 2;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          arst;
  logic          busy;
  logic [CW-1:0] cnt;
  logic          err;

  always #5 clk = ~clk;

  fifo_pkt_reader_if #(.WIDTH(W)) bus ();

  fifo_pkt_reader #(
    .WIDTH(W), .SZ_W(4), .CNT_W(CW), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .arst(arst),
    .bus(bus.master),
    .busy_o(busy),
    .pkt_cnt_o(cnt),
    .error_o(err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic e,
                     input logic [W-1:0] d, input logic rdy);
    @(posedge clk);
    #1;
    arst             = r;
    bus.fifo_empty_i = e;
    bus.fifo_data_i  = d;
    bus.ready_i      = rdy;
    @(negedge clk);
  endtask

  typedef struct {
    logic       r;
    logic       e;
    logic [15:0] d;
    logic       rdy;
    logic       x_rd;
    logic       x_v;
    logic [15:0] x_d;
    logic       x_h;
    logic       x_t;
    logic       x_b;
    logic [1:0] x_c;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic [15:0] d,
                     input logic rdy, input logic xrd, input logic xv,
                     input logic [15:0] xd, input logic xh, input logic xt,
                     input logic xb, input logic [1:0] xc);
    vec_t v;
    v.r = r; v.e = e; v.d = d; v.rdy = rdy;
    v.x_rd = xrd; v.x_v = xv; v.x_d = xd;
    v.x_h = xh; v.x_t = xt; v.x_b = xb; v.x_c = xc;
    tbl.push_back(v);
  endtask

  typedef struct {
    logic [15:0] d;
    logic        h;
    logic        t;
  } fl_t;

  fl_t  q[$];
  fl_t  mreg;
  logic mfull;
  logic mlast_t;
  logic mpop;
  int   mcnt;

  // builds one whole packet with its expected head/tail tags
  task automatic push_pkt();
    int   len;
    fl_t  f;
    len = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 4);
    f.d = {4'(len), 12'($urandom)};
    f.h = 1'b1;
    f.t = (len == 0);
    q.push_back(f);
    for (int i = 1; i <= len; i++) begin
      f.d = 16'($urandom);
      f.h = 1'b0;
      f.t = (i == len);
      q.push_back(f);
    end
  endtask

  initial begin
    arst             = 1'b1;
    bus.fifo_empty_i = 1'b1;
    bus.fifo_data_i  = '0;
    bus.ready_i      = 1'b1;
    repeat (2) @(posedge clk);

    // r e data rdy | rd v data h t busy cnt
    add(1,1,16'hFFFF,1, 0,0,16'h0000,0,0,0,0);
    add(0,0,16'h0ABC,1, 1,0,16'h0000,0,0,0,0);
    add(0,1,16'hFFFF,1, 0,1,16'h0ABC,1,1,0,0);
    add(0,1,16'hFFFF,1, 0,0,16'h0ABC,1,1,0,1);
    add(0,0,16'h2001,1, 1,0,16'h0ABC,1,1,0,1);
    add(0,0,16'h0002,1, 1,1,16'h2001,1,0,1,1);
    add(0,0,16'h0003,1, 1,1,16'h0002,0,0,1,1);
    add(0,0,16'h1004,1, 1,1,16'h0003,0,1,0,1);
    add(0,0,16'h0005,1, 1,1,16'h1004,1,0,1,2);
    add(0,1,16'hFFFF,1, 0,1,16'h0005,0,1,0,2);
    add(0,1,16'hFFFF,1, 0,0,16'h0005,0,1,0,3);
    add(0,0,16'h2001,1, 1,0,16'h0005,0,1,0,3);
    for (int i = 0; i < 4; i++)
      add(0,0,16'h0002,0, 0,1,16'h2001,1,0,1,3);
    add(0,0,16'h0002,1, 1,1,16'h2001,1,0,1,3);
    add(0,0,16'h0003,1, 1,1,16'h0002,0,0,1,3);
    add(0,1,16'hFFFF,1, 0,1,16'h0003,0,1,0,3);
    add(0,1,16'hFFFF,1, 0,0,16'h0003,0,1,0,0);
    add(0,0,16'h3000,1, 1,0,16'h0003,0,1,0,0);
    add(0,0,16'h0001,1, 1,1,16'h3000,1,0,1,0);
    add(1,0,16'h0002,1, 0,1,16'h0001,0,0,1,0);
    add(0,1,16'hFFFF,1, 0,0,16'h0000,0,0,0,0);
    add(0,0,16'h0011,1, 1,0,16'h0000,0,0,0,0);
    add(0,1,16'hFFFF,1, 0,1,16'h0011,1,1,0,0);
    add(0,0,16'h0021,1, 1,0,16'h0011,1,1,0,1);
    add(0,0,16'h0022,1, 1,1,16'h0021,1,1,0,1);
    add(0,0,16'h0023,1, 1,1,16'h0022,1,1,0,2);
    add(0,0,16'h0024,1, 1,1,16'h0023,1,1,0,3);
    add(0,1,16'hFFFF,1, 0,1,16'h0024,1,1,0,0);
    add(0,1,16'hFFFF,1, 0,0,16'h0024,1,1,0,1);

    foreach (tbl[i]) begin
      string s;
      cyc(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].rdy);
      s = $sformatf("vec%0d", i);
      chk({s, ".rd"},    bus.fifo_rd_o, tbl[i].x_rd);
      chk({s, ".valid"}, bus.valid_o,   tbl[i].x_v);
      chk({s, ".data"},  bus.data_o,    tbl[i].x_d);
      chk({s, ".head"},  bus.head_o,    tbl[i].x_h);
      chk({s, ".tail"},  bus.tail_o,    tbl[i].x_t);
      chk({s, ".busy"},  busy,          tbl[i].x_b);
      chk({s, ".cnt"},   cnt,           tbl[i].x_c);
      chk({s, ".err"},   err,           1'b0);
    end

    // body stall: head 0x2000 plus one body, then FIFO runs dry
    cyc(0, 0, 16'h2000, 1);
    chk("stall.rd0", bus.fifo_rd_o, 1'b1);
    cyc(0, 0, 16'h0001, 1);
    chk("stall.rd1", bus.fifo_rd_o, 1'b1);
    chk("stall.head", bus.head_o, 1'b1);
    chk("stall.busy0", busy, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 16'hFFFF, 1);
`ifdef FIFO_RD_TIMEOUT_EN
      chk($sformatf("to.err%0d", i), err, (i == 5));
      chk($sformatf("to.busy%0d", i), busy, (i < 5));
`else
      chk($sformatf("wait.err%0d", i), err, 1'b0);
      chk($sformatf("wait.busy%0d", i), busy, 1'b1);
`endif
      chk($sformatf("stall.cnt%0d", i), cnt, 2'd1);
    end
`ifdef FIFO_RD_TIMEOUT_EN
    cyc(0, 0, 16'h0033, 1);
    cyc(0, 1, 16'hFFFF, 1);
    chk("to.next.data", bus.data_o, 16'h0033);
    chk("to.next.head", bus.head_o, 1'b1);
    chk("to.next.tail", bus.tail_o, 1'b1);
`else
    cyc(0, 0, 16'h0044, 1);
    cyc(0, 1, 16'hFFFF, 1);
    chk("wait.next.data", bus.data_o, 16'h0044);
    chk("wait.next.head", bus.head_o, 1'b0);
    chk("wait.next.tail", bus.tail_o, 1'b1);
`endif
    chk("stall.next.busy", busy, 1'b0);
    cyc(0, 1, 16'hFFFF, 1);
    chk("stall.next.cnt", cnt, 2'd2);

    // randomized whole-packet traffic with random backpressure
    cyc(1, 1, 16'hFFFF, 1);
    mfull   = 1'b0;
    mlast_t = 1'b1;
    mpop    = 1'b0;
    mcnt    = 0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      if (mfull && bus.ready_i && mreg.t) mcnt++;
      if (mpop) begin
        mreg    = q.pop_front();
        mfull   = 1'b1;
        mlast_t = mreg.t;
      end else if (mfull && bus.ready_i) begin
        mfull = 1'b0;
      end
      if (q.size() < 24 && $urandom_range(0, 2) == 0) push_pkt();
      arst             = 1'b0;
      bus.ready_i      = ($urandom_range(0, 3) != 0);
      bus.fifo_empty_i = (q.size() == 0);
      bus.fifo_data_i  = (q.size() == 0) ? 16'($urandom) : q[0].d;
      @(negedge clk);
      mpop = !bus.fifo_empty_i && (!mfull || bus.ready_i);
      chk("rnd.rd",    bus.fifo_rd_o, mpop);
      chk("rnd.valid", bus.valid_o,   mfull);
      if (mfull) begin
        chk("rnd.data", bus.data_o, mreg.d);
        chk("rnd.head", bus.head_o, mreg.h);
        chk("rnd.tail", bus.tail_o, mreg.t);
      end
      chk("rnd.busy", busy, !mlast_t);
      chk("rnd.cnt",  cnt,  32'(mcnt % 4));
      chk("rnd.err",  err,  1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
